ff_phase_scheduler: RTL and testbench

Sequencer between the upstream AER event source and the LRF core array. It runs one sample as one inference phase, or as a positive phase followed by a negative phase in training. It drives the array-wide IS_POS / IS_TRAIN controls and forwards input events with a four-phase req/ack handshake. A phase closes only once every core has reported ONE_SAMPLE_FINISH, with a watchdog that flags a timeout.

---
 rtl/ff_phase_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ff_phase_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_phase_scheduler.sv
// Sample sequencer between the AER source and the LRF core array: runs one
// inference phase or a positive/negative training pair, forwarding events 4-phase.
module ff_phase_scheduler #(
    parameter int unsigned CORE_NUM  = 64,
    parameter int unsigned AER_WIDTH = 12,
    parameter int unsigned GAP_CYC   = 4,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 START,
    input  logic                 MODE_TRAIN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    input  logic                 SRC_REQ,
    input  logic [AER_WIDTH-1:0] SRC_ADDR,
    input  logic                 SRC_LAST,
    output logic                 SRC_ACK,
    output logic                 ARR_REQ,
    output logic [AER_WIDTH-1:0] ARR_ADDR,
    input  logic                 ARR_ACK,
    input  logic [CORE_NUM-1:0]  CORE_FINISH,
    output logic                 IS_POS,
    output logic                 IS_TRAIN
);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        IDLE, ARM, STREAM, FWD_REQ, FWD_ACK, WAIT_FIN, GAP, FIN
    } state_t;

    state_t               state, state_d;
    logic                 mode, mode_d;
    logic                 phase, phase_d;
    logic                 last, last_d;
    logic [CORE_NUM-1:0]  mask, mask_d;
    logic [TIMEOUT_W-1:0] wdog, wdog_d;
    logic [GAP_W-1:0]     gap_cnt, gap_d;
    logic                 busy_d, done_d, err_d, src_ack_d, arr_req_d, is_pos_d, is_train_d;
    logic [AER_WIDTH-1:0] addr_d;
    logic                 timeout;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        mode_d     = mode;
        phase_d    = phase;
        last_d     = last;
        mask_d     = mask;
        wdog_d     = wdog;
        gap_d      = gap_cnt;
        busy_d     = BUSY;
        done_d     = 1'b0;
        err_d      = ERR;
        src_ack_d  = SRC_ACK;
        arr_req_d  = ARR_REQ;
        addr_d     = ARR_ADDR;
        is_pos_d   = IS_POS;
        is_train_d = IS_TRAIN;
        // Last watchdog step (or already saturated) counts as a timeout.
        timeout    = (wdog >= WD_LAST);

        if (state inside {STREAM, FWD_REQ, FWD_ACK, WAIT_FIN})
            mask_d = mask | CORE_FINISH;

        unique case (state)
            IDLE: begin
                if (START) begin
                    state_d = ARM;
                    mode_d  = MODE_TRAIN;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ARM: begin
                is_train_d = mode;
                is_pos_d   = ~phase;
                mask_d     = '0;
                wdog_d     = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                if (SRC_REQ && !SRC_ACK && !ARR_ACK) begin
                    addr_d  = SRC_ADDR;
                    last_d  = SRC_LAST;
                    state_d = FWD_REQ;
                end
            end
            FWD_REQ: begin
                if (ARR_ACK) begin
                    arr_req_d = 1'b0;
                    src_ack_d = 1'b1;
                    state_d   = FWD_ACK;
                end else begin
                    arr_req_d = 1'b1;
                end
            end
            FWD_ACK: begin
                if (!SRC_REQ && !ARR_ACK) begin
                    src_ack_d = 1'b0;
                    state_d   = last ? WAIT_FIN : STREAM;
                end
            end
            WAIT_FIN: begin
                if (wdog != WD_MAX)
                    wdog_d = wdog + TIMEOUT_W'(1);
                if (timeout)
                    err_d = 1'b1;
                if ((&mask) || timeout) begin
                    if (mode && !phase) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                    phase_d = 1'b1;
                    state_d = ARM;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode     <= 1'b0;
            phase    <= 1'b0;
            last     <= 1'b0;
            mask     <= '0;
            wdog     <= '0;
            gap_cnt  <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            SRC_ACK  <= 1'b0;
            ARR_REQ  <= 1'b0;
            ARR_ADDR <= '0;
            IS_POS   <= 1'b0;
            IS_TRAIN <= 1'b0;
        end else begin
            state    <= state_d;
            mode     <= mode_d;
            phase    <= phase_d;
            last     <= last_d;
            mask     <= mask_d;
            wdog     <= wdog_d;
            gap_cnt  <= gap_d;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ERR      <= err_d;
            SRC_ACK  <= src_ack_d;
            ARR_REQ  <= arr_req_d;
            ARR_ADDR <= addr_d;
            IS_POS   <= is_pos_d;
            IS_TRAIN <= is_train_d;
        end
    end
endmodule

// File: tb/tb_ff_phase_scheduler.sv
// Scoreboard bench for ff_phase_scheduler: source driver, mapper responder and
// cycle-exact checks of phase sequencing, gap, finish mask and watchdog.
module tb_ff_phase_scheduler;
    localparam int unsigned CORE_NUM  = 64;
    localparam int unsigned AER_WIDTH = 12;
    localparam int unsigned GAP_CYC   = 4;
    localparam int unsigned TIMEOUT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 START, MODE_TRAIN, BUSY, DONE, ERR;
    logic                 SRC_REQ, SRC_LAST, SRC_ACK;
    logic [AER_WIDTH-1:0] SRC_ADDR, ARR_ADDR;
    logic                 ARR_REQ, ARR_ACK;
    logic [CORE_NUM-1:0]  CORE_FINISH;
    logic                 IS_POS, IS_TRAIN;

    ff_phase_scheduler #(
        .CORE_NUM(CORE_NUM), .AER_WIDTH(AER_WIDTH),
        .GAP_CYC(GAP_CYC), .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk(clk), .rst(rst), .START(START), .MODE_TRAIN(MODE_TRAIN),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .SRC_REQ(SRC_REQ), .SRC_ADDR(SRC_ADDR), .SRC_LAST(SRC_LAST), .SRC_ACK(SRC_ACK),
        .ARR_REQ(ARR_REQ), .ARR_ADDR(ARR_ADDR), .ARR_ACK(ARR_ACK),
        .CORE_FINISH(CORE_FINISH), .IS_POS(IS_POS), .IS_TRAIN(IS_TRAIN)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [AER_WIDTH-1:0] sb_q[$];
    logic [AER_WIDTH-1:0] held_addr;
    int                   stall_cfg  = 0;
    int                   stall_left = 0;
    bit                   req_seen   = 1'b0;

    // Mapper model: pops expected address on each new request, optional stall.
    initial begin
        ARR_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ARR_ACK  = 1'b0;
                req_seen = 1'b0;
            end else if (ARR_REQ && !ARR_ACK) begin
                if (!req_seen) begin
                    req_seen   = 1'b1;
                    held_addr  = ARR_ADDR;
                    stall_left = stall_cfg;
                    check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
                    if (sb_q.size() != 0)
                        check_eq("arr_addr", 64'(ARR_ADDR), 64'(sb_q.pop_front()));
                end else begin
                    check_eq("stall_addr", 64'(ARR_ADDR), 64'(held_addr));
                    check_eq("stall_src_ack", 64'(SRC_ACK), 64'd0);
                end
                if (stall_left == 0) ARR_ACK = 1'b1;
                else stall_left--;
            end else if (!ARR_REQ && ARR_ACK) begin
                ARR_ACK  = 1'b0;
                req_seen = 1'b0;
            end
        end
    end

    task automatic send_ev(input logic [AER_WIDTH-1:0] a, input logic lst, input int hold);
        int t;
        sb_q.push_back(a);
        SRC_ADDR = a;
        SRC_LAST = lst;
        SRC_REQ  = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!SRC_ACK && t < 200);
        check_eq("src_ack_rise", 64'(SRC_ACK), 64'd1);
        repeat (hold) begin
            @(negedge clk);
            check_eq("src_ack_held", 64'(SRC_ACK), 64'd1);
        end
        SRC_REQ = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (SRC_ACK && t < 200);
        check_eq("src_ack_fall", 64'(SRC_ACK), 64'd0);
        SRC_LAST = 1'b0;
    endtask

    task automatic pulse_finish(input logic [CORE_NUM-1:0] bits);
        CORE_FINISH = bits;
        @(negedge clk);
        CORE_FINISH = '0;
    endtask

    // Accept a sample; arm_pulse is driven during the ARM cycle and must be dropped.
    task automatic start_sample(input logic mode, input logic [CORE_NUM-1:0] arm_pulse);
        START      = 1'b1;
        MODE_TRAIN = mode;
        @(negedge clk);
        START      = 1'b0;
        MODE_TRAIN = 1'b0;
        check_eq("busy_after_start", 64'(BUSY), 64'd1);
        check_eq("err_cleared", 64'(ERR), 64'd0);
        pulse_finish(arm_pulse);
        check_eq("is_train", 64'(IS_TRAIN), 64'(mode));
        check_eq("is_pos_p0", 64'(IS_POS), 64'd1);
    endtask

    task automatic finish_expect_done(input logic [CORE_NUM-1:0] bits);
        pulse_finish(bits);
        check_eq("done_early0", 64'(DONE), 64'd0);
        @(negedge clk);
        check_eq("done_early1", 64'(DONE), 64'd0);
        check_eq("busy_hold", 64'(BUSY), 64'd1);
        @(negedge clk);
        check_eq("done_pulse", 64'(DONE), 64'd1);
        check_eq("busy_fall", 64'(BUSY), 64'd0);
        @(negedge clk);
        check_eq("done_single", 64'(DONE), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(BUSY), 64'd0);
        check_eq({tag, "_done"}, 64'(DONE), 64'd0);
        check_eq({tag, "_err"}, 64'(ERR), 64'd0);
        check_eq({tag, "_src_ack"}, 64'(SRC_ACK), 64'd0);
        check_eq({tag, "_arr_req"}, 64'(ARR_REQ), 64'd0);
        check_eq({tag, "_arr_addr"}, 64'(ARR_ADDR), 64'd0);
        check_eq({tag, "_is_pos"}, 64'(IS_POS), 64'd0);
        check_eq({tag, "_is_train"}, 64'(IS_TRAIN), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        rst = 1'b1; START = 1'b0; MODE_TRAIN = 1'b0;
        SRC_REQ = 1'b0; SRC_ADDR = '0; SRC_LAST = 1'b0; CORE_FINISH = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        // Inference, three events
        start_sample(1'b0, '0);
        send_ev(12'h005, 1'b0, 0);
        send_ev(12'h1A3, 1'b0, 0);
        send_ev(12'hFFF, 1'b1, 0);
        finish_expect_done('1);
        check_eq("inf_is_pos_hold", 64'(IS_POS), 64'd1);
        check_eq("inf_is_train_hold", 64'(IS_TRAIN), 64'd0);

        // Training: gap of GAP_CYC cycles before phase-1 ARM
        start_sample(1'b1, '0);
        send_ev(12'h011, 1'b0, 0);
        send_ev(12'h022, 1'b1, 0);
        pulse_finish('1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("gap_is_pos_%0d", i), 64'(IS_POS), 64'd1);
            check_eq($sformatf("gap_busy_%0d", i), 64'(BUSY), 64'd1);
        end
        @(negedge clk);
        check_eq("p1_is_pos", 64'(IS_POS), 64'd0);
        check_eq("p1_is_train", 64'(IS_TRAIN), 64'd1);
        send_ev(12'h033, 1'b0, 0);
        send_ev(12'h044, 1'b1, 0);
        finish_expect_done('1);
        check_eq("trn_is_pos_hold", 64'(IS_POS), 64'd0);
        check_eq("trn_is_train_hold", 64'(IS_TRAIN), 64'd1);

        // Handshake stall and delayed source release
        stall_cfg = 20;
        start_sample(1'b0, '0);
        send_ev(12'h2B7, 1'b1, 3);
        stall_cfg = 0;
        finish_expect_done('1);

        // Early/split finish; ARM-cycle pulse on core 63 is dropped
        start_sample(1'b0, 64'd1 << 63);
        pulse_finish(64'hFF_FFFF_FFFF);
        send_ev(12'h0A0, 1'b0, 0);
        send_ev(12'h0B0, 1'b1, 0);
        pulse_finish(64'h7FFF_FF00_0000_0000);
        repeat (3) begin
            @(negedge clk);
            check_eq("split_no_done", 64'(DONE), 64'd0);
            check_eq("split_busy", 64'(BUSY), 64'd1);
        end
        finish_expect_done(64'd1 << 63);
        check_eq("split_no_err", 64'(ERR), 64'd0);

        // Watchdog: core 7 never finishes
        start_sample(1'b0, '0);
        pulse_finish(~(64'd1 << 7));
        send_ev(12'h3C3, 1'b1, 0);
        t = 0;
        while (!ERR && t < 40) begin @(negedge clk); t++; end
        check_eq("timeout_cycles", 64'(t), 64'd15);
        check_eq("timeout_done_wait", 64'(DONE), 64'd0);
        @(negedge clk);
        check_eq("timeout_done", 64'(DONE), 64'd1);
        check_eq("timeout_busy", 64'(BUSY), 64'd0);
        @(negedge clk);
        check_eq("err_sticky", 64'(ERR), 64'd1);

        // START while busy is ignored, then reset mid-FWD_REQ
        start_sample(1'b0, '0);
        START = 1'b1; MODE_TRAIN = 1'b1;
        @(negedge clk);
        START = 1'b0; MODE_TRAIN = 1'b0;
        @(negedge clk);
        check_eq("busy_start_is_train", 64'(IS_TRAIN), 64'd0);
        check_eq("busy_start_is_pos", 64'(IS_POS), 64'd1);
        check_eq("busy_start_busy", 64'(BUSY), 64'd1);
        send_ev(12'h123, 1'b0, 0);
        stall_cfg = 100;
        sb_q.push_back(12'h155);
        SRC_ADDR = 12'h155; SRC_LAST = 1'b0; SRC_REQ = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ARR_REQ && t < 20);
        check_eq("pre_rst_arr_req", 64'(ARR_REQ), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        SRC_REQ = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_cfg = 0;
        check_eq("sb_after_rst", 64'(sb_q.size()), 64'd0);

        // Recovery after reset
        start_sample(1'b0, '0);
        send_ev(12'h7E1, 1'b1, 0);
        finish_expect_done('1);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
